// File: rtl/prescaler_bank.sv
// Bank of independent programmable clock prescalers sharing one clock.
// Divisor updates are buffered and take effect only at a period boundary.
module prescaler_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 28
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sync,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] divisor,
    output logic [CHANNELS-1:0]       out_clk,
    output logic [CHANNELS-1:0]       tick
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] active_div;
        logic [WIDTH-1:0] pending_div;
        logic [WIDTH-1:0] div_in;
        logic             out_q;
        logic             tick_q;
        logic             term;

        assign div_in = divisor[i*WIDTH +: WIDTH];
        assign term   = (active_div != '0) &&
                        (cnt == active_div - WIDTH'(1));

        always_ff @(posedge clock) begin
            if (!reset) begin
                cnt         <= '0;
                active_div  <= '0;
                pending_div <= '0;
                out_q       <= 1'b0;
                tick_q      <= 1'b0;
            end else if (sync) begin
                cnt    <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
                if (load[i]) pending_div <= div_in;
            end else if (!enable[i]) begin
                cnt    <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
                if (load[i]) begin
                    pending_div <= div_in;
                    active_div  <= div_in;
                end else begin
                    active_div  <= pending_div;
                end
            end else begin
                if (load[i]) pending_div <= div_in;
                if (active_div == '0) begin
                    cnt    <= '0;
                    out_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (term) begin
                    // terminal takes the pending value from before this edge
                    cnt        <= '0;
                    tick_q     <= 1'b1;
                    active_div <= pending_div;
                    out_q      <= mode[i] ? 1'b1 : ~out_q;
                end else begin
                    cnt    <= cnt + WIDTH'(1);
                    tick_q <= 1'b0;
                    if (mode[i]) out_q <= 1'b0;
                end
            end
        end

        assign out_clk[i] = out_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: tb/tb_prescaler_bank.sv
// Randomized and directed checks of prescaler_bank against a
// countdown-based reference model.
module tb_prescaler_bank;
    localparam int CH = 4;
    localparam int W  = 28;

    logic              clock = 1'b0;
    logic              reset;
    logic              sync;
    logic [CH-1:0]     enable;
    logic [CH-1:0]     mode;
    logic [CH-1:0]     load;
    logic [CH*W-1:0]   divisor;
    logic [CH-1:0]     out_clk;
    logic [CH-1:0]     tick;

    int total = 0;
    int bad   = 0;

    int unsigned m_act  [CH];
    int unsigned m_pend [CH];
    int unsigned m_left [CH];
    bit          m_out  [CH];
    bit          m_tick [CH];

    prescaler_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .sync   (sync),
        .enable (enable),
        .mode   (mode),
        .load   (load),
        .divisor(divisor),
        .out_clk(out_clk),
        .tick   (tick)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // m_left = edges remaining until the next terminal count
    function automatic void model_step();
        for (int i = 0; i < CH; i++) begin
            int unsigned d;
            int unsigned old;
            d = int'(divisor[i*W +: W]);
            if (!reset) begin
                m_act[i] = 0; m_pend[i] = 0; m_left[i] = 0;
                m_out[i] = 0; m_tick[i] = 0;
            end else if (sync) begin
                if (load[i]) m_pend[i] = d;
                m_left[i] = m_act[i];
                m_out[i] = 0; m_tick[i] = 0;
            end else if (!enable[i]) begin
                if (load[i]) begin
                    m_pend[i] = d; m_act[i] = d;
                end else begin
                    m_act[i] = m_pend[i];
                end
                m_left[i] = m_act[i];
                m_out[i] = 0; m_tick[i] = 0;
            end else begin
                old = m_pend[i];
                if (load[i]) m_pend[i] = d;
                if (m_act[i] == 0) begin
                    m_left[i] = 0; m_out[i] = 0; m_tick[i] = 0;
                end else if (m_left[i] == 1) begin
                    m_tick[i] = 1;
                    m_act[i]  = old;
                    m_left[i] = old;
                    m_out[i]  = mode[i] ? 1'b1 : !m_out[i];
                end else begin
                    m_left[i] = m_left[i] - 1;
                    m_tick[i] = 0;
                    if (mode[i]) m_out[i] = 0;
                end
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("out_clk%0d", i), 32'(out_clk[i]), 32'(m_out[i]));
            chk($sformatf("tick%0d", i), 32'(tick[i]), 32'(m_tick[i]));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic set_div(input int i, input int unsigned v);
        divisor[i*W +: W] = W'(v);
    endtask

    task automatic wait_left(input int i, input int unsigned v,
                             input string tag);
        int k;
        k = 0;
        while (m_left[i] != v && k < 100) begin
            cyc();
            k++;
        end
        if (k >= 100) chk(tag, 0, 1);
    endtask

    initial begin
        int n;
        int first;
        for (int i = 0; i < CH; i++) begin
            m_act[i] = 0; m_pend[i] = 0; m_left[i] = 0;
            m_out[i] = 0; m_tick[i] = 0;
        end

        // 1: reset with all inputs active
        reset = 0; sync = 1; enable = '1; mode = '1; load = '1;
        for (int i = 0; i < CH; i++) set_div(i, 1);
        run(3);
        chk("rst_out", 32'(out_clk), 0);
        chk("rst_tick", 32'(tick), 0);
        reset = 1; sync = 0; enable = '0; mode = '0; load = '0;
        divisor = '0;
        run(4);
        enable = '1;
        run(4);
        chk("idle_tick", 32'(tick), 0);
        enable = '0;
        run(1);

        // 2: ch0 divide by 5, toggle mode
        set_div(0, 5); load[0] = 1;
        run(1);
        load[0] = 0; enable[0] = 1; mode[0] = 0;
        n = 0;
        for (int k = 0; k < 25; k++) begin
            cyc();
            if (tick[0]) n++;
            if (k == 4) chk("t2_first", 32'(tick[0]), 1);
        end
        chk("t2_ticks", n, 5);

        // 3: ch1 pulse mode, divisor 1 then 3
        set_div(1, 1); load[1] = 1; mode[1] = 1;
        run(1);
        load[1] = 0; enable[1] = 1;
        run(6);
        chk("t3_n1", 32'(tick[1] & out_clk[1]), 1);
        set_div(1, 3); load[1] = 1;
        run(1);
        load[1] = 0;
        run(12);

        // 4: ch2 load on terminal edge
        set_div(2, 4); load[2] = 1;
        run(1);
        load[2] = 0; enable[2] = 1;
        run(3);
        wait_left(2, 1, "t4_wait");
        set_div(2, 7); load[2] = 1;
        run(1);
        load[2] = 0;
        chk("t4_old", m_act[2], 4);
        run(30);

        // 5: sync re-alignment
        enable = '0;
        for (int i = 0; i < CH; i++) set_div(i, i + 2);
        load = '1;
        run(1);
        load = '0; enable = '1; mode = 4'b0101;
        run(13);
        sync = 1;
        run(1);
        chk("sync_out", 32'(out_clk), 0);
        chk("sync_tick", 32'(tick), 0);
        sync = 0;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (tick[3] && first == 0) first = k;
        end
        chk("t5_first3", first, 5);

        // 6: reset and disable mid-period
        enable = '0; set_div(0, 6); load[0] = 1;
        run(1);
        load[0] = 0; enable[0] = 1;
        wait_left(0, 3, "t6_wait1");
        reset = 0;
        run(1);
        chk("t6_rst", 32'(out_clk | tick), 0);
        reset = 1; enable[0] = 0; load[0] = 1;
        run(1);
        load[0] = 0; enable[0] = 1;
        wait_left(0, 3, "t6_wait2");
        enable[0] = 0;
        run(1);
        chk("t6_dis", 32'({out_clk[0], tick[0]}), 0);
        enable[0] = 1;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (tick[0] && first == 0) first = k;
        end
        chk("t6_restart", first, 6);

        // random traffic
        for (int k = 0; k < 500; k++) begin
            reset  = ($urandom_range(99) != 0);
            sync   = ($urandom_range(49) == 0);
            if ($urandom_range(9) == 0) enable = CH'($urandom);
            if ($urandom_range(7) == 0) mode = CH'($urandom);
            for (int i = 0; i < CH; i++) begin
                load[i] = ($urandom_range(11) == 0);
                set_div(i, $urandom_range(7));
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
